// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the seven-segment scan driver.
// Segment bit order is bit0=a .. bit6=g, logical polarity 1 = lit.
package seven_seg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } state_t;

  localparam int SEG_W = 7;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam logic [SEG_W-1:0] SEG_ALL_OFF_LOGICAL = 7'h00;

endpackage

// File: rtl/seven_seg_slot_timer.sv
// Loadable down-counter timing one BLANK or DRIVE slot.
// Loading N-1 makes o_done pulse on the N-th cycle after the load.
module seven_seg_slot_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic         i_clear,
  input  logic [W-1:0] i_load_val,
  output logic         o_done
);

  logic [W-1:0] r_count;
  logic         r_active;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_count  <= '0;
      r_active <= 1'b0;
    end else if (i_load) begin
      r_count  <= i_load_val;
      r_active <= 1'b1;
    end else if (r_active) begin
      if (r_count == '0) r_active <= 1'b0;
      else               r_count  <= r_count - 1'b1;
    end
  end

  // Qualified by r_active so an expired timer does not keep reporting done.
  assign o_done = r_active && (r_count == '0);

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexes per-digit segment patterns onto a shared bus with a blanking
// gap per slot. Define SEVEN_SEG_DIM_EN to add the 4-bit PWM brightness input.
module seven_seg_scan_driver
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS       = 4,
  parameter int DIGIT_CYCLES     = 50000,
  parameter int BLANK_CYCLES     = 500,
  parameter bit SEG_ACTIVE_LOW   = 1'b1,
  parameter bit DIGIT_ACTIVE_LOW = 1'b1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
`ifdef SEVEN_SEG_DIM_EN
  input  logic [3:0]                  brightness,
`endif
  input  logic [NUM_DIGITS*SEG_W-1:0] seg_in,
  input  logic [NUM_DIGITS-1:0]       dp_in,
  output logic [SEG_W-1:0]            seg_out,
  output logic                        dp_out,
  output logic [NUM_DIGITS-1:0]       digit_out,
  output logic                        frame_start
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int TMR_W = (DIGIT_CYCLES > 2) ? $clog2(DIGIT_CYCLES) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [TMR_W-1:0] BLANK_LOAD = TMR_W'(BLANK_CYCLES - 1);
  localparam logic [TMR_W-1:0] DRIVE_LOAD = TMR_W'(DIGIT_CYCLES - BLANK_CYCLES - 1);

  localparam logic [SEG_W-1:0]      SEG_POL = {SEG_W{SEG_ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] DIG_POL = {NUM_DIGITS{DIGIT_ACTIVE_LOW}};

  state_t                      r_state, w_next_state;
  logic [IDX_W-1:0]            r_index, w_next_index;
  logic                        w_frame_start;
  logic [NUM_DIGITS*SEG_W-1:0] r_shadow_seg;
  logic [NUM_DIGITS-1:0]       r_shadow_dp;

  logic                        w_timer_done;
  logic                        w_timer_load;
  logic                        w_timer_clear;
  logic [TMR_W-1:0]            w_timer_val;

  logic                        w_digit_on;
  logic [SEG_W-1:0]            w_seg_logical;
  logic                        w_dp_logical;
  logic [NUM_DIGITS-1:0]       w_digit_logical;

  // NOTE: every always_comb output gets a default first, so no path through
  // the case/if tree can leave a value held and infer a latch.
  always_comb begin
    w_next_state  = r_state;
    w_next_index  = r_index;
    w_frame_start = 1'b0;
    case (r_state)
      IDLE: begin
        if (enable) begin
          w_next_state  = BLANK;
          w_next_index  = '0;
          w_frame_start = 1'b1;
        end
      end
      BLANK: begin
        if (!enable) begin
          w_next_state = IDLE;
          w_next_index = '0;
        end else if (w_timer_done) begin
          w_next_state = DRIVE;
        end
      end
      DRIVE: begin
        if (!enable) begin
          w_next_state = IDLE;
          w_next_index = '0;
        end else if (w_timer_done) begin
          w_next_state = BLANK;
          if (r_index == LAST_IDX) begin
            w_next_index  = '0;
            w_frame_start = 1'b1;
          end else begin
            w_next_index  = r_index + 1'b1;
          end
        end
      end
      default: begin
        w_next_state = IDLE;
        w_next_index = '0;
      end
    endcase
  end

  // The slot counter reloads on every entry to BLANK or DRIVE.
  assign w_timer_load  = (w_next_state != r_state) && (w_next_state != IDLE);
  assign w_timer_clear = (w_next_state == IDLE);
  assign w_timer_val   = (w_next_state == BLANK) ? BLANK_LOAD : DRIVE_LOAD;

  seven_seg_slot_timer #(
    .W (TMR_W)
  ) u_slot_timer (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_timer_load),
    .i_clear    (w_timer_clear),
    .i_load_val (w_timer_val),
    .o_done     (w_timer_done)
  );

`ifdef SEVEN_SEG_DIM_EN
  logic [3:0] r_pwm;
  logic [3:0] w_pwm_next;

  // Outputs are registered, so gating uses the PWM value of the coming cycle.
  assign w_pwm_next = (r_state == DRIVE) ? r_pwm + 4'd1 : 4'd0;
  assign w_digit_on = (brightness == 4'hF) || (w_pwm_next < brightness);

  always_ff @(posedge clk) begin
    if (reset) r_pwm <= 4'd0;
    else       r_pwm <= w_pwm_next;
  end
`else
  assign w_digit_on = 1'b1;
`endif

  always_comb begin
    w_seg_logical   = SEG_ALL_OFF_LOGICAL;
    w_dp_logical    = 1'b0;
    w_digit_logical = '0;
    if (w_next_state == DRIVE) begin
      w_seg_logical = r_shadow_seg[SEG_W*w_next_index +: SEG_W];
      w_dp_logical  = r_shadow_dp[w_next_index];
      if (w_digit_on) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          w_digit_logical[i] = (w_next_index == IDX_W'(i));
        end
      end
    end
  end

  // NOTE: the shadow pattern registers are reset along with the control state
  // so a frame never displays power-up garbage.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_index      <= '0;
      r_shadow_seg <= '0;
      r_shadow_dp  <= '0;
      seg_out      <= SEG_ALL_OFF_LOGICAL ^ SEG_POL;
      dp_out       <= SEG_ACTIVE_LOW;
      digit_out    <= DIG_POL;
      frame_start  <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_index     <= w_next_index;
      if (w_frame_start) begin
        r_shadow_seg <= seg_in;
        r_shadow_dp  <= dp_in;
      end
      seg_out     <= w_seg_logical ^ SEG_POL;
      dp_out      <= w_dp_logical ^ SEG_ACTIVE_LOW;
      digit_out   <= w_digit_logical ^ DIG_POL;
      frame_start <= w_frame_start;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed bench for seven_seg_scan_driver: 4 digits, 8-cycle slots, 2 blank,
// active-low segments and digits. Dimming steps run when SEVEN_SEG_DIM_EN is set.
module tb_seven_seg_scan_driver;

  localparam int ND = 4;
  localparam int DC = 8;
  localparam int BC = 2;
  localparam logic [12:0] OFF = {1'b0, 1'b1, 4'hF, 7'h7F};

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [27:0] seg_in;
  logic [3:0]  dp_in;
  logic [6:0]  seg_out;
  logic        dp_out;
  logic [3:0]  digit_out;
  logic        frame_start;
`ifdef SEVEN_SEG_DIM_EN
  logic [3:0]  brightness;
`endif

  int         checks = 0;
  int         errors = 0;
  int         cur_bright = 15;
  logic [6:0] exp_seg [4];
  logic       exp_dp  [4];

  always #5 clk = ~clk;

  seven_seg_scan_driver #(
    .NUM_DIGITS       (ND),
    .DIGIT_CYCLES     (DC),
    .BLANK_CYCLES     (BC),
    .SEG_ACTIVE_LOW   (1'b1),
    .DIGIT_ACTIVE_LOW (1'b1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
`ifdef SEVEN_SEG_DIM_EN
    .brightness  (brightness),
`endif
    .seg_in      (seg_in),
    .dp_in       (dp_in),
    .seg_out     (seg_out),
    .dp_out      (dp_out),
    .digit_out   (digit_out),
    .frame_start (frame_start)
  );

  // Advance one clock and land on the falling edge, away from the active edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [12:0] obs();
    return {frame_start, dp_out, digit_out, seg_out};
  endfunction

  task automatic check(input string tag, input logic [12:0] got, input logic [12:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, got, want);
    end
  endtask

  // Expected {frame_start, dp, digit, seg} for cycle c counted from a frame start.
  function automatic logic [12:0] exp_vec(input int c);
    int         pos;
    int         d;
    logic       fs;
    logic       lit;
    logic [3:0] one;
    logic [3:0] sel;
    pos = c % DC;
    d   = (c / DC) % ND;
    fs  = ((c % (ND * DC)) == 0);
    one = 4'b0001;
    if (pos < BC) return {fs, 1'b1, 4'hF, 7'h7F};
    lit = (cur_bright == 15) || ((pos - BC) < cur_bright);
    sel = lit ? ~(one << d) : 4'hF;
    return {fs, exp_dp[d], sel, exp_seg[d]};
  endfunction

  task automatic run(input string tag, input int c0, input int c1);
    for (int c = c0; c <= c1; c++) begin
      check($sformatf("%s c=%0d", tag, c), obs(), exp_vec(c));
      step();
    end
  endtask

  initial begin
    reset  = 1'b1;
    enable = 1'b1;
    seg_in = {7'h4F, 7'h5B, 7'h06, 7'h3F};
    dp_in  = 4'b0010;
`ifdef SEVEN_SEG_DIM_EN
    brightness = 4'hF;
`endif
    exp_seg = '{7'h40, 7'h79, 7'h24, 7'h30};
    exp_dp  = '{1'b1, 1'b0, 1'b1, 1'b1};

    // Reset held with enable high: outputs off, no frame pulse.
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("reset_hold %0d", i), obs(), OFF);
    end

    reset = 1'b0;
    step();
    run("scan", 0, 18);

    // Mid-frame pattern change during the digit-2 slot must not tear.
    seg_in[6:0]   = 7'h7F;
    seg_in[27:21] = 7'h00;
    run("scan", 19, 31);
    exp_seg[0] = 7'h00;
    exp_seg[3] = 7'h7F;
    run("capture", 32, 75);

    // Drop enable in the third DRIVE cycle of digit 1.
    check("disable c=76", obs(), exp_vec(76));
    enable = 1'b0;
    seg_in = {7'h6F, 7'h7F, 7'h07, 7'h7D};
    dp_in  = 4'b1000;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("disabled %0d", i), obs(), OFF);
    end

    exp_seg = '{7'h02, 7'h78, 7'h00, 7'h10};
    exp_dp  = '{1'b1, 1'b1, 1'b1, 1'b0};
    enable = 1'b1;
    step();
    run("restart", 0, 27);

    // One-cycle reset pulse during DRIVE of digit 3.
    check("pre_reset c=28", obs(), exp_vec(28));
    reset = 1'b1;
    step();
    check("reset_pulse", obs(), OFF);
    reset = 1'b0;
    step();
    run("post_reset", 0, 9);

`ifdef SEVEN_SEG_DIM_EN
    for (int k = 0; k < 3; k++) begin
      int b;
      b = (k == 0) ? 4 : ((k == 1) ? 15 : 0);
      enable = 1'b0;
      step();
      check($sformatf("dim_idle %0d", b), obs(), OFF);
      brightness = 4'(b);
      cur_bright = b;
      enable = 1'b1;
      step();
      run($sformatf("dim%0d", b), 0, 31);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan_driver.md
Name: seven_seg_scan_driver

Overview:
Downstream consumer of the seven-segment PIO registers. Takes per-digit 7-bit segment patterns (bit0=a … bit6=g, 1=lit) and time-multiplexes them onto one shared segment bus with per-digit enables. Inserts a blanking gap between digits to prevent ghosting. Latches the patterns once per frame so software writes never tear mid-scan.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (1..8)
DIGIT_CYCLES, 50000, clocks per digit slot, blank plus drive (1 ms at 50 MHz)
BLANK_CYCLES, 500, clocks of all-off at the start of each slot (1 ≤ BLANK_CYCLES < DIGIT_CYCLES)
SEG_ACTIVE_LOW, 1, 1 = seg_out/dp_out driven low to light
DIGIT_ACTIVE_LOW, 1, 1 = digit_out driven low to select

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  scan enable
seg_in  in  NUM_DIGITS*7  digit i pattern at seg_in[7*i +: 7], logical polarity
dp_in  in  NUM_DIGITS  decimal point per digit, 1 = lit
seg_out  out  7  shared segment lines, physical polarity
dp_out  out  1  shared decimal point, physical polarity
digit_out  out  NUM_DIGITS  digit select, one-hot when driving, physical polarity
frame_start  out  1  one-cycle pulse at the start of each frame

Behaviour:
- Clock and reset: one clock `clk`; reset `reset` is synchronous and active-high.
- All outputs are registers updated on the same edge as the state. There is no combinational input→output path.
- Reset (sampled high at posedge): state=IDLE, digit index=0, slot counter=0, shadow registers=0. Outputs go to the off levels: seg_out all unlit (7'h7F when active-low), dp_out unlit, digit_out all deselected, frame_start=0. Reset has priority over all other inputs in every state.
- FSM: IDLE, BLANK, DRIVE.
- IDLE: outputs off. When enable=1, go to BLANK with index 0.
- Frame start (each entry to BLANK with index 0, from IDLE or from wrap):
  - capture seg_in/dp_in into shadow registers;
  - frame_start=1 for that cycle only.
- BLANK: lasts BLANK_CYCLES cycles. All digits deselected, segments unlit. Then go to DRIVE.
- DRIVE: lasts DIGIT_CYCLES−BLANK_CYCLES cycles.
  - digit_out selects only the current index;
  - seg_out/dp_out show shadow[index], polarity applied.
  - At end of DRIVE: index increments; after NUM_DIGITS−1 it wraps to 0. Then go to BLANK.
- Frame period is exactly NUM_DIGITS*DIGIT_CYCLES clocks.
- enable sampled 0 in BLANK or DRIVE: next state IDLE, index=0, outputs off after that edge. A later enable=1 restarts at digit 0 with a fresh capture and a frame_start pulse.
- seg_in changes mid-frame are ignored until the next frame start.
- NUM_DIGITS=1: the index stays 0 and every slot is a frame start.
- The slot counter is wide enough for DIGIT_CYCLES−1 and never overflows. It reloads on every state entry.

Optional Feature:
SEVEN_SEG_DIM_EN
- Defined:
  - adds port `brightness  in  4`;
  - a 4-bit PWM counter clears on DRIVE entry and increments each DRIVE cycle, wrapping at 16;
  - the digit is selected only while pwm<brightness, or when brightness=4'hF (full);
  - brightness=0 keeps every digit dark;
  - brightness is sampled live, not shadowed.
- Undefined: port absent; the digit is selected for the whole of DRIVE.

Decomposition:
- Package seven_seg_pkg holds:
  - state enum (IDLE/BLANK/DRIVE);
  - SEG_W=7;
  - segment bit-index constants SEG_A..SEG_G;
  - SEG_ALL_OFF_LOGICAL=7'h00.
- Sub-module seven_seg_slot_timer: loadable down-counter with a one-cycle `done` pulse. Used for both BLANK and DRIVE durations.

Test Plan:
All tests use NUM_DIGITS=4, DIGIT_CYCLES=8, BLANK_CYCLES=2, both active-low.
1. reset high 3 cycles, enable=1 → seg_out=7'h7F, dp_out=1, digit_out=4'hF, frame_start=0 throughout.
2. Scan order:
   - Stimulus: seg_in digits 0..3 = 7'h3F, 7'h06, 7'h5B, 7'h4F; enable rises.
   - Required: frame_start pulses 1 cycle; 2 blank cycles, then 6 cycles of digit_out=4'b1110, seg_out=7'h40.
   - Then 2 blank, then 6 cycles of 4'b1101 / 7'h79; continue through digit 3.
   - frame_start repeats every 32 cycles.
3. seg_in digit0 changed to 7'h7F during the digit-2 slot → digit0 still shows 7'h40 this frame; shows 7'h00 only after the next frame_start.
4. enable dropped in the 3rd DRIVE cycle of digit 1 → all outputs off from the next cycle. Re-enable → frame_start fires, digit 0 first, new seg_in captured.
5. reset pulsed 1 cycle during DRIVE of digit 3 → outputs off next cycle. With enable=1, scan restarts at digit 0 with frame_start.
6. SEVEN_SEG_DIM_EN:
   - brightness=4 → each DRIVE selects the digit for the first 4 of 6 cycles.
   - brightness=15 → all 6 cycles.
   - brightness=0 → digit_out stays 4'hF.
